uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares the single UART transmitter byte FIFO write port between NUM_REQ independent byte sources.
- Each requester streams bytes with a valid/ready/last handshake.
- The arbiter locks a grant for a whole packet, so frames from different sources never interleave on the serial line.
- Sits between software/DMA byte sources and the transmitter's tx_we/din/full interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridden).
- TIMEOUT_CYC, 1024, stall cycles before forced release (used only with the optional feature).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last_i  in  NUM_REQ  marks the final byte of a packet.
- req_ready_o  out  NUM_REQ  per-requester byte accepted this cycle.
- tx_full_i  in  1  transmitter FIFO full.
- tx_we_o  out  1  FIFO write strobe.
- tx_din_o  out  8  FIFO write data.
- grant_o  out  NUM_REQ  one-hot current owner; zero when idle.
- busy_o  out  1  a packet is in progress.
- timeout_o  out  1  one-cycle pulse on forced release (tied 0 when the feature is off).

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, rr_ptr=0, grant_o=0, busy_o=0, req_ready_o=0, tx_we_o=0, tx_din_o=0, timeout_o=0, stall counter=0.
- States:
  - IDLE: when any req_valid_i is set, pick the first set bit searching upward from rr_ptr with wrap. Register it as owner and go to BUSY next cycle. The grant is always one cycle after valid, with no same-cycle grant.
  - BUSY: req_ready_o[owner] = !tx_full_i. All other ready bits are 0.
- Transfer: beat = req_valid_i[owner] && req_ready_o[owner].
  - tx_we_o = beat, combinational in the same cycle.
  - tx_din_o = req_data_i[owner], muxed combinationally; it holds the owner's data while BUSY and is 0 in IDLE.
- End of packet: a beat with req_last_i[owner]=1 moves the block to IDLE and sets rr_ptr = owner+1 (wraps to 0 at NUM_REQ).
  - There is one dead cycle between packets.
  - A requester that just finished has lowest priority in the next arbitration.
- Full backpressure: while tx_full_i=1, no beat occurs and the grant holds. The requester must keep its data stable.
- req_valid_i dropping mid-packet (owner bubbles) keeps the grant. Only last, the timeout, or reset releases it.
- A single-byte packet (valid and last in the first BUSY cycle) takes 2 cycles from request to IDLE.
- req_last_i is ignored unless a beat occurs.
- Reset mid-packet aborts the grant immediately. The partial packet is already in the FIFO and is not recalled.
- grant_o is the registered one-hot owner. busy_o = (state==BUSY).
- The block does not control tx_en or the baud rate.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit stall counter increments each BUSY cycle without a beat and clears on any beat or on IDLE.
  - When the count reaches TIMEOUT_CYC-1 with no beat, the block returns to IDLE, advances rr_ptr past the owner, and pulses timeout_o for 1 cycle.
- When undefined: there is no counter, timeout_o is tied 0, and a grant is held indefinitely until last.

Decomposition:
- Package uart_tx_arb_pkg contains:
  - arb_state_e enum {IDLE, BUSY}.
  - TIMEOUT_W=16.
  - Function rr_pick(req, ptr) returning index plus a found flag.
- Natural sub-module: rr_pick_comb, a purely combinational rotating priority picker.
- The FSM, mux and counter stay in uart_tx_arb.

Test Plan:
- Reset and simultaneous requests: after reset, assert valid on req 0 and req 2 together. Required: req 0 is granted 1 cycle later, and grant_o=4'b0001.
- Rotation: req 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43). Required: tx_we_o pulses 3 times with those values, then IDLE for 1 cycle, then req 2 is granted, so rr_ptr=1 skips to 2.
- Backpressure: hold tx_full_i=1 for 5 cycles mid-packet. Required: req_ready_o=0 and tx_we_o=0 throughout, the grant is unchanged, and the byte is written in the cycle full deasserts.
- No interleave: owner bubbles valid low for 10 cycles while req 1 is valid. Required: no grant change and no tx_we_o; after resumption the bytes stay contiguous until last.
- Starvation and wrap, NUM_REQ=4, all requesters continuously sending 1-byte packets. Required: grant order 0,1,2,3,0 with each packet taking 2 cycles.
- Timeout (macro on, TIMEOUT_CYC=8): owner stalls after 1 byte. Required: timeout_o pulses on the 8th stall cycle, the block returns to IDLE, and the next requester is granted; with the macro off the grant persists for 100 cycles.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and the rotating-priority search used by the UART transmit arbiter.
// The search is written for up to 8 requesters; callers zero-extend narrower request vectors.
package uart_tx_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  localparam int TIMEOUT_W = 16;
  localparam int MAX_REQ   = 8;
  localparam int PICK_W    = 3;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping at n (n <= MAX_REQ, ptr < n).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [PICK_W-1:0]  ptr,
                                    input logic [PICK_W:0]    n);
    pick_t           r;
    logic [PICK_W:0] pos;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = {1'b0, ptr} + (PICK_W+1)'(k);
      if (pos >= n) pos = pos - n;
      if (!r.found && ((PICK_W+1)'(k) < n) && req[pos[PICK_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = pos[PICK_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick_comb.sv
// Purely combinational rotating-priority picker; zero latency, no flow control.
module rr_pick_comb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  pick_t pick;
  logic  unused_idx_hi;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req_i), PICK_W'(ptr_i), (PICK_W+1)'(NUM_REQ));
  end

  assign found_o       = pick.found;
  assign idx_o         = pick.idx[IDX_W-1:0];
  assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter onto the UART TX FIFO write port; grant 1 cycle after valid, beats pass combinationally.
// tx_full_i stalls the owner in place; UART_TX_ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYC stalled cycles.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic                 tx_full_i,
  output logic                 tx_we_o,
  output logic [7:0]           tx_din_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_nxt, pick_idx;
  logic               pick_found, busy, beat, timeout;

  rr_pick_comb #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i  (req_valid_i),
    .ptr_i  (rr_ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  assign busy = (state_q == BUSY);

  always_comb begin
    req_ready_o = '0;
    if (busy) req_ready_o[owner_q] = !tx_full_i;
    beat      = busy && req_valid_i[owner_q] && !tx_full_i;
    tx_we_o   = beat;
    tx_din_o  = busy ? req_data_i[{owner_q, 3'b000} +: 8] : 8'h00;
    owner_nxt = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counter holds the number of stalled cycles before this one, so the release lands on stall TIMEOUT_CYC.
  always_comb begin
    timeout     = busy && !beat && (stall_cnt_q == TIMEOUT_W'(TIMEOUT_CYC-1));
    stall_cnt_d = (busy && !beat && !timeout) ? stall_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end
`else
  logic [TIMEOUT_W-1:0] unused_timeout_cyc;
  assign timeout            = 1'b0;
  assign unused_timeout_cyc = TIMEOUT_W'(TIMEOUT_CYC);
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
        end
      end
      BUSY: begin
        // Pointer moves past the finished owner so it has lowest priority next round.
        if ((beat && req_last_i[owner_q]) || timeout) begin
          state_d  = IDLE;
          rr_ptr_d = owner_nxt;
          grant_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy;
  assign timeout_o = timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: rotation, backpressure, bubbles, wrap and stall release.
module tb_uart_tx_arb;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid, last, ready, grant;
  logic [N*8-1:0] data;
  logic           full, we, busy, tmo;
  logic [7:0]     din;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(valid),
    .req_data_i (data),
    .req_last_i (last),
    .req_ready_o(ready),
    .tx_full_i  (full),
    .tx_we_o    (we),
    .tx_din_o   (din),
    .grant_o    (grant),
    .busy_o     (busy),
    .timeout_o  (tmo)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    valid[i]       = v;
    data[i*8 +: 8] = d;
    last[i]        = l;
  endtask

  logic [3:0] exp_g   [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
  logic [7:0] exp_din [10] = '{8'h00, 8'hC0, 8'h00, 8'hC1, 8'h00, 8'hC2, 8'h00, 8'hC3, 8'h00, 8'hC0};

  initial begin
    rst = 1'b1; valid = '0; last = '0; data = '0; full = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    rst = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_we", we, 0);
    chk("rst_din", din, 0);
    chk("rst_timeout", tmo, 0);

    // Simultaneous requests 0 and 2: no same-cycle grant, req 0 wins
    set_req(0, 1'b1, 8'h41, 1'b0);
    set_req(2, 1'b1, 8'hA0, 1'b0);
    #1;
    chk("same_cyc_grant", grant, 0);
    chk("same_cyc_we", we, 0);
    @(negedge clk); #1;
    chk("first_grant", grant, 4'b0001);
    chk("first_ready", ready, 4'b0001);
    chk("beat41_we", we, 1);
    chk("beat41_din", din, 8'h41);
    @(negedge clk); set_req(0, 1'b1, 8'h42, 1'b0); #1;
    chk("beat42_we", we, 1);
    chk("beat42_din", din, 8'h42);
    @(negedge clk); set_req(0, 1'b1, 8'h43, 1'b1); #1;
    chk("beat43_we", we, 1);
    chk("beat43_din", din, 8'h43);
    @(negedge clk); set_req(0, 1'b0, 8'h00, 1'b0); #1;
    chk("dead_grant", grant, 0);
    chk("dead_busy", busy, 0);
    chk("dead_we", we, 0);
    chk("dead_din", din, 0);

    // Req 2 granted next; hold FIFO full for 5 cycles
    @(negedge clk); set_req(2, 1'b1, 8'hB0, 1'b0); full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("full_grant", grant, 4'b0100);
      chk("full_ready", ready, 0);
      chk("full_we", we, 0);
    end
    @(negedge clk); full = 1'b0; #1;
    chk("unfull_ready", ready, 4'b0100);
    chk("unfull_we", we, 1);
    chk("unfull_din", din, 8'hB0);

    // Owner bubbles for 10 cycles while req 1 waits
    @(negedge clk);
    set_req(2, 1'b0, 8'hB1, 1'b0);
    set_req(1, 1'b1, 8'h11, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("bubble_grant", grant, 4'b0100);
      chk("bubble_we", we, 0);
    end
    @(negedge clk); set_req(2, 1'b1, 8'hB1, 1'b0); #1;
    chk("resume_b1_we", we, 1);
    chk("resume_b1_din", din, 8'hB1);
    @(negedge clk); set_req(2, 1'b1, 8'hB2, 1'b1); #1;
    chk("resume_b2_we", we, 1);
    chk("resume_b2_din", din, 8'hB2);
    @(negedge clk); set_req(2, 1'b0, 8'h00, 1'b0); #1;
    chk("dead2_grant", grant, 0);
    chk("dead2_we", we, 0);
    @(negedge clk); set_req(1, 1'b1, 8'h11, 1'b1); #1;
    chk("req1_grant", grant, 4'b0010);
    chk("req1_we", we, 1);
    chk("req1_din", din, 8'h11);
    @(negedge clk); set_req(1, 1'b0, 8'h00, 1'b0); #1;
    chk("req1_done_busy", busy, 0);

    // All requesters send 1-byte packets continuously from a fresh reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'hC0 + 8'(i), 1'b1);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("rr_grant", grant, exp_g[k]);
      chk("rr_we", we, (exp_g[k] != 4'h0));
      chk("rr_din", din, exp_din[k]);
      @(negedge clk);
    end

    // Owner 3 stalls after one byte while req 0 waits
    rst = 1'b1; valid = '0; last = '0;
    @(negedge clk); rst = 1'b0;
    set_req(3, 1'b1, 8'hD0, 1'b0); #1;
    chk("stall_idle_grant", grant, 0);
    @(negedge clk); #1;
    chk("stall_grant", grant, 4'b1000);
    chk("stall_first_we", we, 1);
    chk("stall_first_din", din, 8'hD0);
    @(negedge clk);
    set_req(3, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'hE0, 1'b1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("tmo_grant", grant, 4'b1000);
      chk("tmo_pulse", tmo, (k == 7));
    end
    @(negedge clk); #1;
    chk("tmo_idle_grant", grant, 0);
    chk("tmo_idle_busy", busy, 0);
    chk("tmo_idle_pulse", tmo, 0);
    @(negedge clk); #1;
    chk("tmo_next_grant", grant, 4'b0001);
    chk("tmo_next_we", we, 1);
    chk("tmo_next_din", din, 8'hE0);
`else
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("hold_grant", grant, 4'b1000);
      chk("hold_timeout", tmo, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
